div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: restoring shift-subtract, one quotient bit per cycle,
// with a fixed 33-cycle start-to-writeback latency and a one-cycle HI/LO write strobe.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvd_q, dvd_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;
  logic        we_q, we_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] trial_s;
  logic [32:0] diff_s;
  logic [31:0] iter_rem_s;
  logic [31:0] iter_quo_s;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    cond_neg = neg ? (32'd0 - v) : v;
  endfunction

  assign busy    = busy_q;
  assign hilo_we = we_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  // Next-state, datapath iteration and result formation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // 33-bit partial remainder: shifted remainder plus next dividend bit.
    trial_s    = {rem_q, quo_q[31]};
    diff_s     = trial_s - {1'b0, dvs_q};
    iter_rem_s = diff_s[32] ? trial_s[31:0] : diff_s[31:0];
    iter_quo_s = {quo_q[30:0], ~diff_s[32]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_BUSY;
          cnt_d     = 6'd0;
          rem_d     = 32'd0;
          quo_d     = cond_neg(dividend, is_signed & dividend[31]);
          dvs_d     = cond_neg(divisor, is_signed & divisor[31]);
          dvd_d     = dividend;
          neg_quo_d = is_signed & (dividend[31] ^ divisor[31]);
          neg_rem_d = is_signed & dividend[31];
          div0_d    = (divisor == 32'd0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        rem_d = iter_rem_s;
        quo_d = iter_quo_s;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
          // Divide-by-zero bypasses sign fix-up so HI returns the raw dividend.
          hi_d    = div0_q ? dvd_q : cond_neg(iter_rem_s, neg_rem_q);
          lo_d    = div0_q ? 32'hFFFF_FFFF : cond_neg(iter_quo_s, neg_quo_q);
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase

    if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end else begin
      cnt_d = cnt_d;
    end

    busy_d = (state_d != S_IDLE);
    we_d   = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      dvd_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed and random divides against an arithmetic
// reference model, plus timing, cancel, back-to-back and asynchronous reset scenarios.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int vecs;
  int errs;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MIPS DIV/DIVU semantics from plain arithmetic.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] d, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / d;
      r = a % d;
    end else if (a == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(d);
      r = $signed(a) % $signed(d);
    end
  endfunction

  // Start one operation in cycle 0 and record busy/hilo_we for cycles 0..34.
  task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic s,
                        output logic [34:0] bt, output logic [34:0] wt,
                        output logic [31:0] hq, output logic [31:0] lq);
    tick();
    start = 1'b1; dividend = a; divisor = d; is_signed = s;
    bt[0] = busy; wt[0] = hilo_we;
    hq = 32'd0; lq = 32'd0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      bt[k] = busy;
      wt[k] = hilo_we;
      if (k == 33) begin
        hq = hi_o;
        lq = lo_o;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    #12;
    vecs++;
    if ({busy, hilo_we, hi_o, lo_o} !== 66'd0) begin
      errs++;
      $display("FAIL reset_state: got busy=%b we=%b hi=%h lo=%h, want all 0", busy, hilo_we, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
    last_hi = 32'd0; last_lo = 32'd0;
  endtask

  task automatic test_directed();
    logic [31:0] va [5];
    logic [31:0] vd [5];
    logic        vs [5];
    logic [34:0] bt, wt, exp_b, exp_w;
    logic [31:0] hq, lq, eq, er;
    va[0] = 32'd100;        vd[0] = 32'd7;          vs[0] = 1'b0;
    va[1] = 32'hFFFF_FFF9;  vd[1] = 32'd2;          vs[1] = 1'b1;
    va[2] = 32'd7;          vd[2] = 32'hFFFF_FFFE;  vs[2] = 1'b1;
    va[3] = 32'h8000_0000;  vd[3] = 32'hFFFF_FFFF;  vs[3] = 1'b1;
    va[4] = 32'h0000_1234;  vd[4] = 32'd0;          vs[4] = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      exp_b[k] = (k >= 1 && k <= 33);
      exp_w[k] = (k == 33);
    end
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vd[i], vs[i], bt, wt, hq, lq);
      ref_div(va[i], vd[i], vs[i], eq, er);
      vecs += 3;
      if (bt !== exp_b) begin
        errs++;
        $display("FAIL directed_busy[%0d]: got %b want %b", i, bt, exp_b);
      end
      if (wt !== exp_w) begin
        errs++;
        $display("FAIL directed_we[%0d]: got %b want %b", i, wt, exp_w);
      end
      if (hq !== er || lq !== eq) begin
        errs++;
        $display("FAIL directed_result[%0d]: got hi=%h lo=%h want hi=%h lo=%h", i, hq, lq, er, eq);
      end
      last_hi = er; last_lo = eq;
    end
  endtask

  task automatic test_random();
    logic [34:0] bt, wt;
    logic [31:0] a, d, hq, lq, eq, er;
    logic        s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: d = 32'd0;
        1: d = $urandom_range(1, 15);
        2: d = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: d = $urandom;
      endcase
      if (i == 0) d = 32'd0;
      s = 1'(($urandom_range(0, 1)));
      run_op(a, d, s, bt, wt, hq, lq);
      ref_div(a, d, s, eq, er);
      vecs += 2;
      if (wt[33] !== 1'b1 || wt[32] !== 1'b0 || wt[34] !== 1'b0) begin
        errs++;
        $display("FAIL random_we[%0d]: got %b want strobe only at cycle 33", i, wt);
      end
      if (hq !== er || lq !== eq) begin
        errs++;
        $display("FAIL random_result[%0d] %h/%h s=%b: got hi=%h lo=%h want hi=%h lo=%h",
                 i, a, d, s, hq, lq, er, eq);
      end
      last_hi = er; last_lo = eq;
    end
  endtask

  task automatic test_cancel();
    logic [31:0] ya, yd, eq, er;
    ya = $urandom; yd = $urandom_range(1, 1000);
    ref_div(ya, yd, 1'b0, eq, er);
    tick();
    start = 1'b1; dividend = 32'd12345; divisor = 32'd3; is_signed = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 10) cancel = 1'b1;
      if (k == 11) begin
        vecs++;
        if (busy !== 1'b0) begin
          errs++;
          $display("FAIL cancel_busy: got %b want 0 in cycle 11", busy);
        end
        cancel = 1'b0; start = 1'b1; dividend = ya; divisor = yd; is_signed = 1'b0;
      end
      if (k == 12) start = 1'b0;
      vecs++;
      if (k < 44 && (hilo_we !== 1'b0 || hi_o !== last_hi || lo_o !== last_lo)) begin
        errs++;
        $display("FAIL cancel_hold[c%0d]: got we=%b hi=%h lo=%h want we=0 hi=%h lo=%h",
                 k, hilo_we, hi_o, lo_o, last_hi, last_lo);
      end else if (k == 44 && (hilo_we !== 1'b1 || hi_o !== er || lo_o !== eq)) begin
        errs++;
        $display("FAIL cancel_restart: got we=%b hi=%h lo=%h want we=1 hi=%h lo=%h",
                 hilo_we, hi_o, lo_o, er, eq);
      end
    end
    last_hi = er; last_lo = eq;
    // Cancel and start together in IDLE: nothing accepted.
    tick();
    start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL cancel_priority: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] aa, ad, ba, bd, aq, ar, bq, br;
    logic        exp_b, exp_w;
    aa = $urandom; ad = $urandom_range(1, 99);
    ba = $urandom; bd = $urandom;
    ref_div(aa, ad, 1'b1, aq, ar);
    ref_div(ba, bd, 1'b0, bq, br);
    tick();
    start = 1'b1; dividend = aa; divisor = ad; is_signed = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k >= 5 && k <= 20) begin
        dividend = $urandom; divisor = $urandom; is_signed = ~is_signed;
        start = k[0];
      end
      if (k == 21) start = 1'b1;
      if (k == 33) begin
        dividend = ba; divisor = bd; is_signed = 1'b0;
      end
      if (k == 35) start = 1'b0;
      exp_b = (k >= 1 && k <= 33) || (k >= 35 && k <= 67);
      exp_w = (k == 33) || (k == 67);
      vecs++;
      if (busy !== exp_b || hilo_we !== exp_w) begin
        errs++;
        $display("FAIL b2b_timing[c%0d]: got busy=%b we=%b want busy=%b we=%b", k, busy, hilo_we, exp_b, exp_w);
      end
      if (k == 33 || k == 67) begin
        vecs++;
        if (hi_o !== (k == 33 ? ar : br) || lo_o !== (k == 33 ? aq : bq)) begin
          errs++;
          $display("FAIL b2b_result[c%0d]: got hi=%h lo=%h want hi=%h lo=%h",
                   k, hi_o, lo_o, (k == 33 ? ar : br), (k == 33 ? aq : bq));
        end
      end
    end
    last_hi = br; last_lo = bq;
  endtask

  task automatic test_reset_mid();
    logic [31:0] eq, er;
    tick();
    start = 1'b1; dividend = 32'd1000; divisor = 32'd9; is_signed = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({busy, hilo_we, hi_o, lo_o} !== 66'd0) begin
      errs++;
      $display("FAIL reset_mid: got busy=%b we=%b hi=%h lo=%h want all 0", busy, hilo_we, hi_o, lo_o);
    end
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      vecs++;
      if (hilo_we !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL reset_after[c%0d]: got busy=%b we=%b want 0 0", k, busy, hilo_we);
      end
    end
    // Start presented together with reset release is taken on the first edge.
    rst = 1'b0;
    tick();
    rst = 1'b1; start = 1'b1; dividend = 32'd77; divisor = 32'd5; is_signed = 1'b0;
    ref_div(32'd77, 32'd5, 1'b0, eq, er);
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 1) begin
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1) begin
          errs++;
          $display("FAIL reset_first_edge: got busy=%b want 1", busy);
        end
      end
      if (k == 33) begin
        vecs++;
        if (hilo_we !== 1'b1 || hi_o !== er || lo_o !== eq) begin
          errs++;
          $display("FAIL reset_first_op: got we=%b hi=%h lo=%h want we=1 hi=%h lo=%h",
                   hilo_we, hi_o, lo_o, er, eq);
        end
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
